// File: rtl/mem_io_responder_pkg.sv
// ============================================================================
//  mem_io_responder_pkg
//  Shared decode constants and stop-FSM state type for mem_io_responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_io_responder_pkg;

    localparam logic [1:0] IO_PAGE     = 2'b11;
    localparam logic [2:0] IO_UART_OFS = 3'd0;
    localparam logic [2:0] IO_CTRL_OFS = 3'd4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STOP_PEND = 2'd1,
        HALTED    = 2'd2
    } stop_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_ram.sv
// ============================================================================
//  byte_ram
//  Synchronous single-port byte RAM, write-first, 2^ADDR_W bytes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module byte_ram #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];

    // Output register holds its value whenever the port is not enabled.
    always_ff @(posedge clk_in) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_o       <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
//  mem_io_responder
//  Byte-wide RAM / memory-mapped IO responder with UART TX FIFO and stop FSM.
//  Optional cycle counter enabled by defining MEM_IO_CYCLE_COUNTER_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 16,
    parameter int TX_MARGIN      = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  in_rx_data,
    input  logic        in_rx_valid,
    output logic        out_rx_pop,
    output logic [7:0]  out_tx_data,
    output logic        out_tx_valid,
    input  logic        in_tx_ready,
    output logic        out_program_stop,
    output logic        out_tx_overflow
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                w_io;
    logic [2:0]          w_ofs;
    logic [7:0]          w_ram_rdata;
    logic [7:0]          w_ctrl_byte;
    logic [7:0]          w_io_rdata;
    logic                unused_ok;

    logic                src_ram_q;
    logic [7:0]          io_rdata_q;

    logic [7:0]          tx_mem_q [TX_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, stop_pos_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, stop_queued_q, stop_popped_q;
    stop_state_t         state_q;

    logic                w_full, w_pop, w_push, w_push_req, w_uart_wr, w_stop_wr;
    logic                w_pop_stop, w_stop_done;
    logic [7:0]          w_push_byte;

    assign w_io      = (mem_a[17:16] == IO_PAGE);
    assign w_ofs     = mem_a[2:0];
    assign unused_ok = ^mem_a[31:18];

    byte_ram #(
        .ADDR_W (RAM_ADDR_WIDTH)
    ) u_ram (
        .clk_in  (clk_in),
        .en_i    (rdy_in & ~w_io),
        .we_i    (mem_wr),
        .addr_i  (mem_a[RAM_ADDR_WIDTH-1:0]),
        .wdata_i (mem_dout),
        .rdata_o (w_ram_rdata)
    );

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic [31:8] snap_q;

    // Byte 0 of the snapshot is served straight from the counter as it is latched.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_q <= '0;
            snap_q  <= '0;
        end else if (rdy_in) begin
            cycle_q <= cycle_q + 32'd1;
            if (w_io && !mem_wr && w_ofs == IO_CTRL_OFS) begin
                snap_q <= cycle_q[31:8];
            end
        end
    end

    always_comb begin
        case (w_ofs[1:0])
            2'd0:    w_ctrl_byte = cycle_q[7:0];
            2'd1:    w_ctrl_byte = snap_q[15:8];
            2'd2:    w_ctrl_byte = snap_q[23:16];
            default: w_ctrl_byte = snap_q[31:24];
        endcase
    end
`else
    assign w_ctrl_byte = 8'h00;
`endif

    always_comb begin
        w_io_rdata = 8'h00;
        if (!mem_wr) begin
            if (w_ofs == IO_UART_OFS) begin
                w_io_rdata = in_rx_valid ? in_rx_data : 8'h00;
            end else if (w_ofs[2]) begin
                w_io_rdata = w_ctrl_byte;
            end
        end
    end

    assign out_rx_pop = rdy_in & ~mem_wr & w_io & (w_ofs == IO_UART_OFS) & in_rx_valid;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            src_ram_q  <= 1'b0;
            io_rdata_q <= 8'h00;
        end else if (rdy_in) begin
            src_ram_q  <= ~w_io;
            io_rdata_q <= w_io_rdata;
        end
    end

    assign mem_din = src_ram_q ? w_ram_rdata : io_rdata_q;

    // Pop is decided first, so a full FIFO can still accept a push in the same cycle.
    assign w_full      = (count_q == CNT_W'(TX_DEPTH));
    assign w_pop       = (count_q != '0) && in_tx_ready;
    assign w_uart_wr   = rdy_in & mem_wr & w_io & (w_ofs == IO_UART_OFS);
    assign w_stop_wr   = rdy_in & mem_wr & w_io & (w_ofs == IO_CTRL_OFS) & (state_q == RUN);
    assign w_push_req  = (w_uart_wr & (mem_dout != 8'h00)) | w_stop_wr;
    assign w_push_byte = w_stop_wr ? 8'h00 : mem_dout;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_pop_stop  = w_pop & stop_queued_q & (rd_ptr_q == stop_pos_q);
    assign w_stop_done = stop_popped_q | w_pop_stop;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            tx_mem_q[wr_ptr_q] <= w_push_byte;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            state_q       <= RUN;
            stop_pos_q    <= '0;
            stop_queued_q <= 1'b0;
            stop_popped_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (w_push_req && !w_push) overflow_q <= 1'b1;

            case (state_q)
                RUN: begin
                    // A dropped stop byte counts as already popped so the FSM can still halt.
                    if (w_stop_wr) begin
                        state_q       <= STOP_PEND;
                        stop_pos_q    <= wr_ptr_q;
                        stop_queued_q <= w_push;
                        stop_popped_q <= ~w_push;
                    end
                end
                STOP_PEND: begin
                    if (w_pop_stop) begin
                        stop_queued_q <= 1'b0;
                        stop_popped_q <= 1'b1;
                    end
                    if (w_stop_done && count_d == '0) begin
                        state_q <= HALTED;
                    end
                end
                HALTED:  state_q <= HALTED;
                default: state_q <= RUN;
            endcase
        end
    end

    assign out_tx_valid     = (count_q != '0);
    assign out_tx_data      = out_tx_valid ? tx_mem_q[rd_ptr_q] : 8'h00;
    assign out_tx_overflow  = overflow_q;
    assign io_buffer_full   = (count_q >= CNT_W'(TX_DEPTH - TX_MARGIN));
    assign out_program_stop = (state_q == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
//  tb_mem_io_responder
//  Directed, table-driven self-checking bench for mem_io_responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  in_rx_data = '0;
    logic        in_rx_valid = 1'b0;
    logic        out_rx_pop;
    logic [7:0]  out_tx_data;
    logic        out_tx_valid;
    logic        in_tx_ready = 1'b0;
    logic        out_program_stop;
    logic        out_tx_overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_cnt;
    logic [31:0] exp_snap;
    logic [7:0]  stop_bytes [4];

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  dout;
        logic [7:0]  rxd;
        logic        rxv;
        logic        exp_pop;
        logic        chk_din;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t vecs [15];

    mem_io_responder dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din),
        .io_buffer_full   (io_buffer_full),
        .in_rx_data       (in_rx_data),
        .in_rx_valid      (in_rx_valid),
        .out_rx_pop       (out_rx_pop),
        .out_tx_data      (out_tx_data),
        .out_tx_valid     (out_tx_valid),
        .in_tx_ready      (in_tx_ready),
        .out_program_stop (out_program_stop),
        .out_tx_overflow  (out_tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: counts rising edges with rdy_in high since reset.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) model_cnt <= '0;
        else if (rdy_in) model_cnt <= model_cnt + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in   = rdy;
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h00123, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h00123, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 1'b1, 32'h00010, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h00010, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 32'h00010, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[5]  = '{1'b0, 1'b0, 32'h30000, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[6]  = '{1'b1, 1'b0, 32'h30000, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
        vecs[7]  = '{1'b1, 1'b0, 32'h30000, 8'h00, 8'h77, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 32'h2FFFF, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 32'h0FFFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3};
        vecs[10] = '{1'b1, 1'b0, 32'h30002, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 32'h10003, 8'h6E, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 32'h30003, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 1'b0, 32'h10003, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h6E};
        vecs[14] = '{1'b1, 1'b0, 32'h30006, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        stop_bytes[0] = 8'h11;
        stop_bytes[1] = 8'h22;
        stop_bytes[2] = 8'h33;
        stop_bytes[3] = 8'h00;

        // Reset state
        repeat (2) tick();
        chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
        chk("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        chk("rst_rx_pop", {31'h0, out_rx_pop}, 32'h0);
        chk("rst_tx_valid", {31'h0, out_tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, out_tx_data}, 32'h0);
        chk("rst_prog_stop", {31'h0, out_program_stop}, 32'h0);
        chk("rst_overflow", {31'h0, out_tx_overflow}, 32'h0);
        rst_in = 1'b0;

        // Table-driven bus cycles
        for (int i = 0; i < 15; i++) begin
            bus(vecs[i].rdy, vecs[i].wr, vecs[i].a, vecs[i].dout);
            in_rx_data  = vecs[i].rxd;
            in_rx_valid = vecs[i].rxv;
            #1;
            chk($sformatf("vec%0d_rx_pop", i), {31'h0, out_rx_pop}, {31'h0, vecs[i].exp_pop});
            tick();
            if (vecs[i].chk_din)
                chk($sformatf("vec%0d_mem_din", i), {24'h0, mem_din}, {24'h0, vecs[i].exp_din});
        end
        in_rx_valid = 1'b0;
        chk("io_ofs3_no_push", {31'h0, out_tx_valid}, 32'h0);

        // UART TX ordering and zero-byte suppression
        in_tx_ready = 1'b1;
        bus(1'b1, 1'b1, 32'h30000, 8'h41);
        tick();
        chk("tx_first_valid", {31'h0, out_tx_valid}, 32'h1);
        chk("tx_first_data", {24'h0, out_tx_data}, 32'h41);
        bus(1'b1, 1'b1, 32'h30000, 8'h42);
        tick();
        chk("tx_second_data", {24'h0, out_tx_data}, 32'h42);
        bus(1'b1, 1'b1, 32'h30000, 8'h00);
        tick();
        chk("tx_zero_ignored", {31'h0, out_tx_valid}, 32'h0);

        // Fill to full, push+pop on full, then overflow
        in_tx_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            bus(1'b1, 1'b1, 32'h30000, 8'(k));
            tick();
            chk($sformatf("fill%0d_buf_full", k), {31'h0, io_buffer_full}, (k >= 14) ? 32'h1 : 32'h0);
        end
        chk("full_no_overflow", {31'h0, out_tx_overflow}, 32'h0);
        in_tx_ready = 1'b1;
        bus(1'b1, 1'b1, 32'h30000, 8'd17);
        tick();
        chk("pushpop_full_overflow", {31'h0, out_tx_overflow}, 32'h0);
        chk("pushpop_full_head", {24'h0, out_tx_data}, 32'h02);
        in_tx_ready = 1'b0;
        bus(1'b1, 1'b1, 32'h30000, 8'd18);
        tick();
        chk("overflow_set", {31'h0, out_tx_overflow}, 32'h1);

        // Partial drain with rdy_in low, then asynchronous reset mid-drain
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        in_tx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("drain%0d_data", k), {24'h0, out_tx_data}, 32'(k + 2));
            chk($sformatf("drain%0d_buf_full", k), {31'h0, io_buffer_full}, (16 - k >= 14) ? 32'h1 : 32'h0);
            tick();
        end
        chk("drain_valid_before_rst", {31'h0, out_tx_valid}, 32'h1);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_tx_valid", {31'h0, out_tx_valid}, 32'h0);
        chk("async_rst_overflow", {31'h0, out_tx_overflow}, 32'h0);
        chk("async_rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        tick();
        rst_in = 1'b0;
        in_tx_ready = 1'b0;

        // Cycle counter snapshot (rdy_in low on every fourth cycle)
        for (int k = 0; k < 400; k++) begin
            bus((k % 4) != 3, 1'b0, 32'h0, 8'h00);
            tick();
        end
        bus(1'b1, 1'b0, 32'h30004, 8'h00);
`ifdef MEM_IO_CYCLE_COUNTER_EN
        exp_snap = model_cnt;
`else
        exp_snap = 32'h0;
`endif
        tick();
        chk("snap_byte0", {24'h0, mem_din}, {24'h0, exp_snap[7:0]});
        bus(1'b1, 1'b0, 32'h30005, 8'h00);
        tick();
        chk("snap_byte1", {24'h0, mem_din}, {24'h0, exp_snap[15:8]});
        bus(1'b1, 1'b0, 32'h30006, 8'h00);
        tick();
        chk("snap_byte2", {24'h0, mem_din}, {24'h0, exp_snap[23:16]});
        bus(1'b1, 1'b0, 32'h30007, 8'h00);
        tick();
        chk("snap_byte3", {24'h0, mem_din}, {24'h0, exp_snap[31:24]});

        // Stop handshake with three bytes queued ahead of the stop byte
        for (int k = 0; k < 3; k++) begin
            bus(1'b1, 1'b1, 32'h30000, stop_bytes[k]);
            tick();
        end
        bus(1'b1, 1'b1, 32'h30004, 8'hFF);
        tick();
        chk("stop_pend_no_stop", {31'h0, out_program_stop}, 32'h0);
        bus(1'b1, 1'b1, 32'h30004, 8'hFF);
        tick();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        in_tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stop_q%0d_valid", k), {31'h0, out_tx_valid}, 32'h1);
            chk($sformatf("stop_q%0d_data", k), {24'h0, out_tx_data}, {24'h0, stop_bytes[k]});
            chk($sformatf("stop_q%0d_not_halted", k), {31'h0, out_program_stop}, 32'h0);
            tick();
        end
        chk("halted_after_stop_pop", {31'h0, out_program_stop}, 32'h1);
        chk("halted_fifo_empty", {31'h0, out_tx_valid}, 32'h0);
        repeat (3) tick();
        chk("halted_sticky", {31'h0, out_program_stop}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
